// File: rtl/simmem_release_scheduler.sv
// Release scheduler for the simulated memory controller: per-slot delay countdown,
// same-ID age ordering, round-robin grant with lock. Optional macro SIMMEM_SCHED_STATS_EN.
module simmem_release_scheduler #(
  parameter int NumSlots     = 8,
  parameter int IDWidth      = 4,
  parameter int CounterWidth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [IDWidth-1:0]            req_id_i,
  input  logic [CounterWidth-1:0]       req_delay_i,
  output logic [$clog2(NumSlots)-1:0]   req_slot_o,
  output logic                          release_valid_o,
  input  logic                          release_ready_i,
  output logic [IDWidth-1:0]            release_id_o,
  output logic [NumSlots-1:0]           release_en_o,
  output logic [$clog2(NumSlots):0]     occupancy_o
`ifdef SIMMEM_SCHED_STATS_EN
  ,
  output logic [31:0]                   stat_releases_o,
  output logic [31:0]                   stat_stall_cycles_o
`endif
);

  localparam int SlotW = $clog2(NumSlots);
  localparam int OccW  = SlotW + 1;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_COUNT, SLOT_READY} slot_state_t;

  slot_state_t             state_reg [NumSlots];
  slot_state_t             state_next [NumSlots];
  logic [CounterWidth-1:0] cnt_reg [NumSlots];
  logic [CounterWidth-1:0] cnt_next [NumSlots];
  logic [IDWidth-1:0]      id_reg [NumSlots];
  logic [IDWidth-1:0]      id_next [NumSlots];
  // older_reg[i][j] set means slot j was allocated before slot i and is still pending
  logic [NumSlots-1:0]     older_reg [NumSlots];
  logic [NumSlots-1:0]     older_next [NumSlots];
  logic [SlotW-1:0]        ptr_reg, ptr_next;
  logic                    lock_reg, lock_next;
  logic [SlotW-1:0]        lock_idx_reg, lock_idx_next;

  logic [NumSlots-1:0]                busy, ready_now, blocked, eligible;
  logic [NumSlots-1:0][NumSlots-1:0]  same_id;
  logic [SlotW-1:0]                   free_idx, arb_idx, cand, grant_idx;
  logic                               arb_found, accept, handshake;
  logic [NumSlots-1:0]                rel_mask;
  logic [OccW-1:0]                    occ;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NumSlots; gi++) begin : g_slot
      assign busy[gi]      = (state_reg[gi] != SLOT_FREE);
      // A counting slot is releasable in the same cycle its counter reads zero
      assign ready_now[gi] = (state_reg[gi] == SLOT_READY) ||
                             ((state_reg[gi] == SLOT_COUNT) && (cnt_reg[gi] == '0));
      for (gj = 0; gj < NumSlots; gj++) begin : g_cmp
        assign same_id[gi][gj] = (id_reg[gi] == id_reg[gj]);
      end
      assign blocked[gi]  = |(older_reg[gi] & busy & same_id[gi]);
      assign eligible[gi] = ready_now[gi] && !blocked[gi];
    end
  endgenerate

  always_comb begin
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = SlotW'(i);
    end
    occ = '0;
    for (int i = 0; i < NumSlots; i++) begin
      occ = occ + OccW'(busy[i]);
    end
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_reg;
    cand      = ptr_reg;
    for (int k = 0; k < NumSlots; k++) begin
      cand = ptr_reg + SlotW'(k);
      if (!arb_found && eligible[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign grant_idx       = lock_reg ? lock_idx_reg : arb_idx;
  assign release_valid_o = lock_reg || arb_found;
  assign release_en_o    = release_valid_o ? (NumSlots'(1) << grant_idx) : '0;
  assign release_id_o    = release_valid_o ? id_reg[grant_idx] : '0;
  assign handshake       = release_valid_o && release_ready_i;
  assign rel_mask        = handshake ? release_en_o : '0;

  assign req_ready_o = !(&busy);
  assign req_slot_o  = free_idx;
  assign occupancy_o = occ;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    lock_next     = lock_reg;
    lock_idx_next = lock_idx_reg;
    ptr_next      = ptr_reg;
    if (release_valid_o && !release_ready_i) begin
      lock_next     = 1'b1;
      lock_idx_next = grant_idx;
    end else if (handshake) begin
      lock_next = 1'b0;
      ptr_next  = grant_idx + SlotW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      state_next[i] = state_reg[i];
      cnt_next[i]   = cnt_reg[i];
      id_next[i]    = id_reg[i];
      older_next[i] = older_reg[i] & ~rel_mask;
      if (rel_mask[i]) begin
        state_next[i] = SLOT_FREE;
        older_next[i] = '0;
      end else begin
        case (state_reg[i])
          SLOT_FREE: begin
            if (accept && (free_idx == SlotW'(i))) begin
              state_next[i] = SLOT_COUNT;
              cnt_next[i]   = req_delay_i;
              id_next[i]    = req_id_i;
              older_next[i] = busy & ~rel_mask;
            end
          end
          SLOT_COUNT: begin
            if (cnt_reg[i] == '0) state_next[i] = SLOT_READY;
            else                  cnt_next[i]   = cnt_reg[i] - CounterWidth'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_reg[i] <= SLOT_FREE;
        cnt_reg[i]   <= '0;
        id_reg[i]    <= '0;
        older_reg[i] <= '0;
      end
      ptr_reg      <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        state_reg[i] <= state_next[i];
        cnt_reg[i]   <= cnt_next[i];
        id_reg[i]    <= id_next[i];
        older_reg[i] <= older_next[i];
      end
      ptr_reg      <= ptr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

`ifdef SIMMEM_SCHED_STATS_EN
  logic [31:0] releases_reg, stall_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      releases_reg <= '0;
      stall_reg    <= '0;
    end else begin
      if (handshake && (releases_reg != 32'hFFFF_FFFF))
        releases_reg <= releases_reg + 32'd1;
      if (release_valid_o && !release_ready_i && (stall_reg != 32'hFFFF_FFFF))
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stat_releases_o     = releases_reg;
  assign stat_stall_cycles_o = stall_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/simmem_release_scheduler.md
Name: simmem_release_scheduler

Overview:
Controller that sequences the release of buffered read-data / write-response entries in the simulated memory controller.
- Each accepted request (ID + programmed delay) is allocated a slot, and the slot's delay is counted down.
- Slots whose delay has expired are arbited round-robin.
- Exactly one slot per handshake is granted to the message banks as a one-hot release enable.
- AXI same-ID ordering is preserved: a slot never releases before an older pending slot with the same ID.

Parameters:
NumSlots, 8, number of tracked outstanding entries (power of 2, >=2)
IDWidth, 4, AXI ID width
CounterWidth, 8, delay counter width; max delay 2^CounterWidth-1 cycles

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  new entry request
req_ready_o  out  1  a free slot exists
req_id_i  in  IDWidth  AXI ID of entry
req_delay_i  in  CounterWidth  release delay in cycles
req_slot_o  out  $clog2(NumSlots)  slot index allocated on accept (valid with req_ready_o)
release_valid_o  out  1  a granted slot is offered
release_ready_i  in  1  banks consume release
release_id_o  out  IDWidth  ID of granted slot
release_en_o  out  NumSlots  one-hot grant; all-zero when release_valid_o=0
occupancy_o  out  $clog2(NumSlots)+1  number of non-FREE slots

Behaviour:
- Reset (synchronous, rst_i=1 at posedge):
  - All slots go FREE; RR pointer=0; lock cleared.
  - Outputs after reset: req_ready_o=1, req_slot_o=0, release_valid_o=0, release_en_o=0, release_id_o=0, occupancy_o=0.
  - Reset mid-operation discards all pending slots with no release issued.
- Per-slot FSM: FREE -> COUNT (on accept) -> READY (counter==0) -> FREE (on release handshake).
- Accept (req_valid_i && req_ready_o):
  - Allocate the lowest-index FREE slot; req_slot_o shows that index combinationally.
  - Load counter=req_delay_i and store the ID.
  - Mark the slot younger than every currently non-FREE slot (NumSlots x NumSlots age matrix).
- Countdown:
  - In COUNT, the counter decrements by 1 per cycle and never goes below 0.
  - The slot enters READY the cycle the counter is 0. Delay d accepted at cycle t is eligible at cycle t+1+d (d=0 -> t+1).
- Eligibility: READY and no older non-FREE slot with an equal ID, whether that slot is in COUNT or READY.
- Arbitration:
  - Round-robin over eligible slots, starting at the RR pointer, wrapping at NumSlots-1 -> 0.
  - On handshake, the pointer moves to granted index+1 (mod NumSlots).
- Grant lock: once release_valid_o=1, the grant (release_en_o, release_id_o) is held unchanged until release_ready_i=1, even if other slots become eligible.
- Handshake:
  - release_valid_o && release_ready_i frees the slot at that clock edge; its age-matrix row and column are cleared.
  - The freed slot is not reusable in the same cycle; it is visible to req_ready_o from the next cycle.
- Simultaneous accept and release of different slots in one cycle: both take effect; occupancy_o is unchanged.
- Full: occupancy_o=NumSlots gives req_ready_o=0; a request presented then must be held by the requester.
- Outputs are combinational from registered state, except req_ready_o, which depends only on registered state. There is no combinational path from req_valid_i to any output.

Optional Feature:
Macro SIMMEM_SCHED_STATS_EN.
- Defined: adds ports stat_releases_o (out, 32) and stat_stall_cycles_o (out, 32).
  - stat_releases_o counts release handshakes.
  - stat_stall_cycles_o counts cycles with release_valid_o=1 && release_ready_i=0.
  - Both saturate at 2^32-1 and are cleared by rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> req_ready_o=1, release_valid_o=0, release_en_o=0, occupancy_o=0 for 10 cycles.
- Accept ID=3 delay=3 at cycle 5, release_ready_i=1 -> release_valid_o=1 first at cycle 9, release_en_o=8'b00000001, release_id_o=3; occupancy_o returns to 0 at cycle 10.
- Same-ID ordering: accept ID=1 delay=10 (slot0) and the next cycle ID=1 delay=0 (slot1) -> slot1 not released before slot0; grants in order slot0, slot1.
- Round-robin: slots 0,1,2 with IDs 0,1,2 all READY simultaneously, ready=1 -> grants 0,1,2 on consecutive cycles. A new eligible slot 0 afterwards is granted only after the pointer wraps.
- Backpressure: grant on slot 2 with release_ready_i=0 for 5 cycles while slot 0 becomes eligible -> release_en_o stays 8'b00000100; slot 2 is freed on the first ready cycle.
- Full: 8 accepts with delay=20 -> req_ready_o=0, occupancy_o=8. Release one slot and accept in the same cycle -> the accept is refused that cycle and succeeds the next. With SIMMEM_SCHED_STATS_EN, stat_stall_cycles_o matches the count of stalled cycles.
